uart_cmd_parser_32bit: RTL and testbench
========================================

Name: uart_cmd_parser_32bit

Overview:
- Consumes bytes that the UART receiver has written into the RX FIFO and assembles them into 32-bit register read/write commands.
- Executes each command on a simple register bus.
- Writes response bytes into the TX FIFO for the UART transmitter.
- Sits between the RX/TX byte FIFOs and the design's control-register file, giving the host full 32-bit register access over the serial link.

Parameters:
- BYTE_TIMEOUT, 24'd1_000_000, clk cycles allowed between consecutive bytes of one frame before the frame is aborted.
- RD_TIMEOUT, 16'd255, clk cycles allowed from reg_rd_en to reg_rd_valid before the read is failed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_fifo_empty  in  1  RX FIFO empty
- rx_fifo_rd_en  out  1  RX FIFO read strobe; data appears on rx_fifo_rd_data the next cycle
- rx_fifo_rd_data  in  8  RX FIFO read data
- tx_fifo_full  in  1  TX FIFO full
- tx_fifo_wr_en  out  1  TX FIFO write strobe
- tx_fifo_wr_data  out  8  TX FIFO write data
- reg_wr_en  out  1  one-cycle register write strobe
- reg_rd_en  out  1  one-cycle register read strobe
- reg_addr  out  16  register address
- reg_wr_data  out  32  register write data
- reg_rd_data  in  32  register read data; sampled when reg_rd_valid=1
- reg_rd_valid  in  1  read data valid
- frame_err  out  1  one-cycle pulse on bad opcode, byte timeout or read timeout

Behaviour:
- Reset values: all outputs 0. State is IDLE, all counters and holding registers cleared.
- Frame format, all multi-byte fields MSB first:
  - Sync byte 0xA5.
  - Opcode: 0x01 = write, 0x02 = read.
  - addr[15:8], addr[7:0].
  - Write frames only: data[31:24] .. data[7:0].
- Byte fetch:
  - Assert rx_fifo_rd_en for exactly one cycle when rx_fifo_empty=0 and no fetch is outstanding.
  - The byte is captured the following cycle.
  - Only one fetch is in flight at a time, so the maximum rate is one byte per 2 cycles.
- States and transitions:
  - IDLE: fetch bytes and discard everything except 0xA5. On 0xA5 go to OPC.
  - OPC:
    - 0x01 or 0x02 → ADDR with byte counter = 2.
    - Any other value → push response 0xEE, pulse frame_err, return to IDLE.
  - ADDR: shift bytes into reg_addr. After the 2nd byte go to DATA (write, counter = 4) or RD_REQ (read).
  - DATA: shift bytes into reg_wr_data. After the 4th byte go to WR_EXEC.
  - WR_EXEC: reg_wr_en=1 for one cycle, then RESP with the 1-byte queue {0x5A}.
  - RD_REQ: reg_rd_en=1 for one cycle, then RD_WAIT.
  - RD_WAIT:
    - On reg_rd_valid: latch reg_rd_data and go to RESP with queue {0x5A, d[31:24], d[23:16], d[15:8], d[7:0]}.
    - If RD_TIMEOUT cycles elapse first: queue {0xEE}, pulse frame_err.
    - If reg_rd_valid and the timeout land in the same cycle, valid wins.
  - RESP:
    - Drive tx_fifo_wr_en=1 for one cycle per byte, and only when tx_fifo_full=0. Stall with no write while full.
    - After the last byte go to IDLE.
- reg_addr and reg_wr_data hold their values until the next frame loads them.
- reg_wr_en and reg_rd_en are never high together, and never high outside WR_EXEC / RD_REQ.
- Byte timeout:
  - A counter runs in OPC, ADDR and DATA. It clears whenever a byte is captured.
  - When it reaches BYTE_TIMEOUT: pulse frame_err, return to IDLE, send no response.
  - The counter is inactive in IDLE.
- A 0xA5 byte received mid-frame is treated as ordinary data, with no resync.
- Asserting rst_n low mid-frame or mid-response aborts immediately. Any partially sent response is not resumed.
- frame_err is registered and lasts exactly one cycle per error event.

Test Plan:
- Write: RX bytes A5 01 12 34 DE AD BE EF → one reg_wr_en pulse with reg_addr=0x1234, reg_wr_data=0xDEADBEEF; TX receives 5A; no frame_err.
- Read: A5 02 00 10, reg_rd_valid 3 cycles after reg_rd_en with data 0xCAFEF00D → TX receives 5A CA FE F0 0D in order; reg_wr_en never asserted.
- Garbage then bad opcode: 00 FF A5 07 → leading bytes discarded; TX receives EE; frame_err pulses once; next frame A5 01 ... executes normally.
- Byte timeout with BYTE_TIMEOUT=100: A5 01 12, then 150 idle cycles → frame_err at cycle 100 after the last byte; no register access; no TX output.
- Read timeout with RD_TIMEOUT=8: A5 02 00 20 with reg_rd_valid never asserted → TX receives EE; frame_err pulses once; a later reg_rd_valid is ignored.
- TX backpressure: hold tx_fifo_full=1 for 20 cycles during a read response → no tx_fifo_wr_en while full; all 5 bytes delivered in order after release.

Source files
------------

// File: rtl/uart_cmd_parser_32bit.sv
// Host command parser: assembles A5-framed 32-bit register read/write commands
// from the RX byte FIFO, runs them on the register bus and queues replies to the TX FIFO.
module uart_cmd_parser_32bit #(
  parameter logic [23:0] BYTE_TIMEOUT = 24'd1_000_000,
  parameter logic [15:0] RD_TIMEOUT   = 16'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd_en,
  input  logic [7:0]  rx_fifo_rd_data,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_wr_en,
  output logic [7:0]  tx_fifo_wr_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wr_data,
  input  logic [31:0] reg_rd_data,
  input  logic        reg_rd_valid,
  output logic        frame_err
);

  localparam int unsigned RESP_W = 40;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CNT_W  = 3;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;
  localparam logic [7:0] ACK   = 8'h5A;
  localparam logic [7:0] NAK   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADDR, S_DATA, S_WR_EXEC, S_RD_REQ, S_RD_WAIT, S_RESP
  } state_t;

  state_t              state_q, state_n;
  logic                byte_vld_q;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                is_wr_q, is_wr_n;
  logic [23:0]         to_q, to_n;
  logic [15:0]         rto_q, rto_n;
  logic [RESP_W-1:0]   resp_q, resp_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [15:0]         addr_n;
  logic [31:0]         wdata_n;
  logic                rd_en_n;
  logic                err_n;

  // TX strobe is gated by the live full flag so a write never lands on a full FIFO.
  assign tx_fifo_wr_en   = (state_q == S_RESP) && !tx_fifo_full;
  assign tx_fifo_wr_data = resp_q[RESP_W-1 -: 8];

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    is_wr_n = is_wr_q;
    to_n    = '0;
    rto_n   = rto_q;
    resp_n  = resp_q;
    len_n   = len_q;
    addr_n  = reg_addr;
    wdata_n = reg_wr_data;
    err_n   = 1'b0;
    rd_en_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_vld_q && rx_fifo_rd_data == SYNC) state_n = S_OPC;
      end
      S_OPC: begin
        if (byte_vld_q) begin
          if (rx_fifo_rd_data == OP_WR || rx_fifo_rd_data == OP_RD) begin
            is_wr_n = (rx_fifo_rd_data == OP_WR);
            cnt_n   = CNT_W'(2);
            state_n = S_ADDR;
          end else begin
            resp_n  = {NAK, 32'h0};
            len_n   = LEN_W'(1);
            err_n   = 1'b1;
            state_n = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (byte_vld_q) begin
          addr_n = {reg_addr[7:0], rx_fifo_rd_data};
          cnt_n  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (is_wr_q) begin
              cnt_n   = CNT_W'(4);
              state_n = S_DATA;
            end else begin
              state_n = S_RD_REQ;
            end
          end
        end
      end
      S_DATA: begin
        if (byte_vld_q) begin
          wdata_n = {reg_wr_data[23:0], rx_fifo_rd_data};
          cnt_n   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_n = S_WR_EXEC;
        end
      end
      S_WR_EXEC: begin
        resp_n  = {ACK, 32'h0};
        len_n   = LEN_W'(1);
        state_n = S_RESP;
      end
      S_RD_REQ: begin
        rto_n   = '0;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Valid data takes priority over a timeout landing in the same cycle.
        if (reg_rd_valid) begin
          resp_n  = {ACK, reg_rd_data};
          len_n   = LEN_W'(5);
          state_n = S_RESP;
        end else if (rto_q == RD_TIMEOUT - 16'd1) begin
          resp_n  = {NAK, 32'h0};
          len_n   = LEN_W'(1);
          err_n   = 1'b1;
          state_n = S_RESP;
        end else begin
          rto_n = rto_q + 16'd1;
        end
      end
      S_RESP: begin
        if (!tx_fifo_full) begin
          resp_n = {resp_q[RESP_W-9:0], 8'h00};
          len_n  = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Inter-byte timeout; abandons the frame silently apart from frame_err.
    if ((state_q == S_OPC || state_q == S_ADDR || state_q == S_DATA) && !byte_vld_q) begin
      if (to_q == BYTE_TIMEOUT - 24'd1) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end else begin
        to_n = to_q + 24'd1;
      end
    end

    // Fetch only for states that will consume the byte, one read in flight at a time.
    rd_en_n = !rx_fifo_empty && !rx_fifo_rd_en &&
              (state_n == S_IDLE || state_n == S_OPC || state_n == S_ADDR || state_n == S_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      byte_vld_q    <= 1'b0;
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      to_q          <= '0;
      rto_q         <= '0;
      resp_q        <= '0;
      len_q         <= '0;
      reg_addr      <= '0;
      reg_wr_data   <= '0;
      rx_fifo_rd_en <= 1'b0;
      reg_wr_en     <= 1'b0;
      reg_rd_en     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state_q       <= state_n;
      byte_vld_q    <= rx_fifo_rd_en;
      cnt_q         <= cnt_n;
      is_wr_q       <= is_wr_n;
      to_q          <= to_n;
      rto_q         <= rto_n;
      resp_q        <= resp_n;
      len_q         <= len_n;
      reg_addr      <= addr_n;
      reg_wr_data   <= wdata_n;
      rx_fifo_rd_en <= rd_en_n;
      reg_wr_en     <= (state_n == S_WR_EXEC);
      reg_rd_en     <= (state_n == S_RD_REQ);
      frame_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser_32bit.sv
// Bench for uart_cmd_parser_32bit: FIFO/register-bus models around the DUT,
// directed frames from the test plan followed by randomized frames against a frame-level model.
module tb_uart_cmd_parser_32bit;

  localparam logic [23:0] BT = 24'd100;
  localparam logic [15:0] RT = 16'd8;

  logic        clk;
  logic        rst_n;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_fifo_rd_en;
  logic [7:0]  rx_fifo_rd_data = 8'h00;
  logic        tx_fifo_full = 1'b0;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data = 32'h0;
  logic        reg_rd_valid = 1'b0;
  logic        frame_err;

  uart_cmd_parser_32bit #(.BYTE_TIMEOUT(BT), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_rd_data(rx_fifo_rd_data),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wr_data(tx_fifo_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  rx_mem [0:1023];
  int          rx_wr_ptr = 0;
  int          rx_rd_ptr = 0;
  int          rx_underflow = 0;
  int          last_pop = 0;
  logic [7:0]  tx_got [0:1023];
  int          tx_cnt = 0;
  int          wr_while_full = 0;
  logic [15:0] wa_log [0:255];
  logic [31:0] wd_log [0:255];
  int          wr_cnt = 0;
  int          rd_reqs = 0;
  int          both_en = 0;
  int          err_cnt = 0;
  int          last_err = 0;
  int          rd_delay = 0;
  int          rd_cd = 0;
  logic [31:0] rd_value = 32'h0;
  logic        late_req = 1'b0;
  logic        force_full = 1'b0;
  logic        rand_bp = 1'b0;
  logic [7:0]  exp_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d, limit 60000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // RX FIFO: data presented the cycle after the read strobe.
  always @(posedge clk) begin
    if (rx_fifo_rd_en) begin
      if (rx_rd_ptr != rx_wr_ptr) begin
        rx_fifo_rd_data <= rx_mem[rx_rd_ptr[9:0]];
        rx_rd_ptr       <= rx_rd_ptr + 1;
        last_pop        <= cyc;
        rx_fifo_empty   <= (rx_rd_ptr + 1 == rx_wr_ptr);
      end else begin
        rx_underflow  <= rx_underflow + 1;
        rx_fifo_empty <= 1'b1;
      end
    end else begin
      rx_fifo_empty <= (rx_rd_ptr == rx_wr_ptr);
    end
  end

  always @(posedge clk) begin
    if (tx_fifo_wr_en) begin
      if (tx_fifo_full) wr_while_full <= wr_while_full + 1;
      tx_got[tx_cnt[9:0]] <= tx_fifo_wr_data;
      tx_cnt <= tx_cnt + 1;
    end
  end

  always @(negedge clk)
    tx_fifo_full <= force_full | (rand_bp & ($urandom_range(0, 2) == 0));

  // Register bus slave: rd_delay cycles of latency, 0 means never answer.
  always @(posedge clk) begin
    reg_rd_data  <= rd_value;
    reg_rd_valid <= late_req | (rd_cd == 1);
    if (reg_wr_en) begin
      wa_log[wr_cnt[7:0]] <= reg_addr;
      wd_log[wr_cnt[7:0]] <= reg_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_wr_en && reg_rd_en) both_en <= both_en + 1;
    if (reg_rd_en) begin
      rd_reqs <= rd_reqs + 1;
      rd_cd   <= rd_delay;
    end else if (rd_cd != 0) begin
      rd_cd <= rd_cd - 1;
    end
  end

  always @(posedge clk)
    if (frame_err) begin
      err_cnt  <= err_cnt + 1;
      last_err <= cyc;
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr_ptr[9:0]] = b;
    rx_wr_ptr = rx_wr_ptr + 1;
  endtask

  task automatic send_write(input logic [15:0] a, input logic [31:0] d);
    push(8'hA5); push(8'h01); push(a[15:8]); push(a[7:0]);
    push(d[31:24]); push(d[23:16]); push(d[15:8]); push(d[7:0]);
  endtask

  task automatic send_read(input logic [15:0] a);
    push(8'hA5); push(8'h02); push(a[15:8]); push(a[7:0]);
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(tx_cnt >= n), 64'd1);
  endtask

  // Compare TX bytes from base onwards against exp_q.
  task automatic check_tx(input string tag, input int base);
    check({tag, "_count"}, 64'(tx_cnt - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] idx;
      idx = 10'(base + i);
      check($sformatf("%s_byte%0d", tag, i), 64'(tx_got[idx]), 64'(exp_q[i]));
    end
  endtask

  // Expected read reply: ACK then the data word MSB first.
  task automatic model_read(input logic [31:0] d);
    exp_q.delete();
    exp_q.push_back(8'h5A);
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
  endtask

  initial begin
    int tb, wb, eb, rb, k;
    logic [15:0] a;
    logic [31:0] d;
    logic [7:0]  g;
    logic        is_wr;

    rst_n = 1'b0;
    idle(3);
    check("rst_rx_rd_en", 64'(rx_fifo_rd_en), 64'd0);
    check("rst_tx_wr_en", 64'(tx_fifo_wr_en), 64'd0);
    check("rst_tx_data",  64'(tx_fifo_wr_data), 64'd0);
    check("rst_reg_wr_en", 64'(reg_wr_en), 64'd0);
    check("rst_reg_rd_en", 64'(reg_rd_en), 64'd0);
    check("rst_reg_addr", 64'(reg_addr), 64'd0);
    check("rst_reg_wdata", 64'(reg_wr_data), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Write frame
    tb = tx_cnt; wb = wr_cnt; eb = err_cnt;
    send_write(16'h1234, 32'hDEADBEEF);
    wait_tx(tb + 1, 200, "wr_resp_arrive");
    idle(5);
    exp_q.delete(); exp_q.push_back(8'h5A);
    check_tx("wr_tx", tb);
    check("wr_pulses", 64'(wr_cnt - wb), 64'd1);
    check("wr_addr", 64'(wa_log[wb[7:0]]), 64'h1234);
    check("wr_data", 64'(wd_log[wb[7:0]]), 64'hDEADBEEF);
    check("wr_no_err", 64'(err_cnt - eb), 64'd0);
    check("wr_addr_hold", 64'(reg_addr), 64'h1234);

    // Read frame, 3-cycle slave latency
    tb = tx_cnt; wb = wr_cnt; eb = err_cnt; rb = rd_reqs;
    rd_value = 32'hCAFEF00D; rd_delay = 3;
    send_read(16'h0010);
    wait_tx(tb + 5, 200, "rd_resp_arrive");
    idle(5);
    model_read(32'hCAFEF00D);
    check_tx("rd_tx", tb);
    check("rd_no_write", 64'(wr_cnt - wb), 64'd0);
    check("rd_one_req", 64'(rd_reqs - rb), 64'd1);
    check("rd_no_err", 64'(err_cnt - eb), 64'd0);

    // Garbage then bad opcode, then a good frame
    tb = tx_cnt; wb = wr_cnt; eb = err_cnt;
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h07);
    wait_tx(tb + 1, 200, "bad_op_arrive");
    idle(5);
    exp_q.delete(); exp_q.push_back(8'hEE);
    check_tx("bad_op_tx", tb);
    check("bad_op_err", 64'(err_cnt - eb), 64'd1);
    check("bad_op_no_wr", 64'(wr_cnt - wb), 64'd0);
    tb = tx_cnt;
    send_write(16'hABCD, 32'h01234567);
    wait_tx(tb + 1, 200, "after_bad_arrive");
    idle(5);
    exp_q.delete(); exp_q.push_back(8'h5A);
    check_tx("after_bad_tx", tb);
    check("after_bad_wdata", 64'(wd_log[wb[7:0]]), 64'h01234567);

    // Byte timeout mid-frame
    tb = tx_cnt; wb = wr_cnt; eb = err_cnt; rb = rd_reqs;
    push(8'hA5); push(8'h01); push(8'h12);
    idle(150);
    check("bto_err", 64'(err_cnt - eb), 64'd1);
    check("bto_latency", 64'((last_err - last_pop) >= 95 && (last_err - last_pop) <= 110), 64'd1);
    check("bto_no_tx", 64'(tx_cnt - tb), 64'd0);
    check("bto_no_wr", 64'(wr_cnt - wb), 64'd0);
    check("bto_no_rd", 64'(rd_reqs - rb), 64'd0);

    // Read timeout, then a stray late valid
    tb = tx_cnt; wb = wr_cnt; eb = err_cnt;
    rd_delay = 0;
    send_read(16'h0020);
    wait_tx(tb + 1, 200, "rto_arrive");
    idle(5);
    exp_q.delete(); exp_q.push_back(8'hEE);
    check_tx("rto_tx", tb);
    check("rto_err", 64'(err_cnt - eb), 64'd1);
    late_req = 1'b1;
    @(negedge clk);
    late_req = 1'b0;
    idle(10);
    check("rto_late_no_tx", 64'(tx_cnt - tb), 64'd1);
    check("rto_late_no_err", 64'(err_cnt - eb), 64'd1);
    check("rto_no_wr", 64'(wr_cnt - wb), 64'd0);

    // TX backpressure across a read reply
    tb = tx_cnt; rb = rd_reqs;
    rd_value = 32'h13579BDF; rd_delay = 2;
    force_full = 1'b1;
    send_read(16'h0040);
    k = 0;
    while (rd_reqs == rb && k < 200) begin @(negedge clk); k++; end
    check("bp_rd_seen", 64'(rd_reqs - rb), 64'd1);
    idle(20);
    check("bp_held", 64'(tx_cnt - tb), 64'd0);
    force_full = 1'b0;
    wait_tx(tb + 5, 200, "bp_arrive");
    idle(5);
    model_read(32'h13579BDF);
    check_tx("bp_tx", tb);

    // Randomized frames with garbage prefixes and random backpressure
    for (int it = 0; it < 24; it++) begin
      rand_bp = it[0];
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h3C;
        push(g);
      end
      is_wr = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      d = $urandom;
      rd_value = $urandom;
      rd_delay = int'($urandom_range(1, 6));
      tb = tx_cnt; wb = wr_cnt; eb = err_cnt;
      if (is_wr) begin
        exp_q.delete(); exp_q.push_back(8'h5A);
        send_write(a, d);
      end else begin
        model_read(rd_value);
        send_read(a);
      end
      wait_tx(tb + exp_q.size(), 400, $sformatf("rnd%0d_arrive", it));
      idle(3);
      check_tx($sformatf("rnd%0d_tx", it), tb);
      check($sformatf("rnd%0d_wr", it), 64'(wr_cnt - wb), 64'(is_wr));
      if (is_wr) begin
        check($sformatf("rnd%0d_addr", it), 64'(wa_log[wb[7:0]]), 64'(a));
        check($sformatf("rnd%0d_data", it), 64'(wd_log[wb[7:0]]), 64'(d));
      end
      check($sformatf("rnd%0d_err", it), 64'(err_cnt - eb), 64'd0);
    end
    rand_bp = 1'b0;
    idle(5);

    check("no_rx_underflow", 64'(rx_underflow), 64'd0);
    check("no_wr_rd_overlap", 64'(both_en), 64'd0);
    check("no_write_while_full", 64'(wr_while_full), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
